// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// i2c_target_regs: I2C target exposing a 16 x 8 register file with a 4-bit pointer.
// Register 0x0B is a read-only ID register. Define I2C_TARGET_AUTOINC_EN to make the
// pointer advance after every data byte; otherwise it stays fixed within a transaction.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'b1001011,
  parameter logic [7:0] ID_VALUE = 8'hCB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       busy,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic [3:0] PtrStep = 4'd1;
`else
  localparam logic [3:0] PtrStep = 4'd0;
`endif

  localparam logic [3:0] IdIndex = 4'hB;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  state_e      state_q;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  tx_q;
  logic        ack_phase_q;
  logic        sda_oe_q;
  logic [3:0]  ptr_q;
  logic [7:0]  regs_q [16];

  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic        addr_match;

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_done  = scl_rise && (bit_cnt_q == 3'd7);
  assign rx_byte    = {shift_q[6:0], sda_s};
  assign addr_match = (shift_q[7:1] == DEV_ADDR);

  // Open-drain: only ever pull low or release.
  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign rd_data = regs_q[rd_addr];

  // Two-flop synchronizers plus one history flop for edge detection; reset to bus-idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Protocol FSM with registered SDA drive, busy and write-strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= 4'h0;
      wr_data     <= 8'h00;
      ptr_q       <= 4'h0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
              ack_phase_q <= 1'b0;
              if (state_q == StAddr) begin
                state_q <= StAddrAck;
              end else if (state_q == StPtr) begin
                state_q <= StPtrAck;
                ptr_q   <= rx_byte[3:0];
              end else begin
                state_q   <= StWdataAck;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr_q;
                wr_data   <= rx_byte;
                ptr_q     <= ptr_q + PtrStep;
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_fall && !ack_phase_q) begin
              // Fall ending the 8th bit: start the ACK, or drop out on a foreign address.
              if (state_q == StAddrAck && !addr_match) begin
                state_q <= StIgnore;
              end else begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
                if (state_q == StAddrAck) busy <= 1'b1;
              end
            end else if (scl_fall) begin
              // Fall ending the ACK clock.
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              if (state_q == StAddrAck && shift_q[0]) begin
                state_q  <= StRdata;
                tx_q     <= regs_q[ptr_q];
                sda_oe_q <= ~regs_q[ptr_q][7];
              end else if (state_q == StAddrAck) begin
                state_q <= StPtr;
              end else begin
                state_q <= StWdata;
              end
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q     <= StRdataAck;
                ack_phase_q <= 1'b0;
                ptr_q       <= ptr_q + PtrStep;
              end
            end else if (scl_fall) begin
              tx_q     <= {tx_q[6:0], 1'b0};
              sda_oe_q <= ~tx_q[6];
            end
          end
          StRdataAck: begin
            if (scl_fall && !ack_phase_q) begin
              sda_oe_q    <= 1'b0;
              ack_phase_q <= 1'b1;
            end else if (scl_rise && ack_phase_q && sda_s) begin
              state_q <= StIgnore;
            end else if (scl_fall && ack_phase_q) begin
              // Initiator ACKed: present the next byte.
              state_q   <= StRdata;
              bit_cnt_q <= 3'd0;
              tx_q      <= regs_q[ptr_q];
              sda_oe_q  <= ~regs_q[ptr_q][7];
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register file; the ID register ignores writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      regs_q[IdIndex] <= ID_VALUE;
    end else if (wr_strobe && (wr_addr != IdIndex)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Directed bench for i2c_target_regs: bit-banged I2C initiator with hand-computed expectations.
module tb_i2c_target_regs;

  localparam time Q = 100ns;  // quarter SCL period; SCL = 400 ns vs 10 ns clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  wire        sda;
  logic       busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int n0;
  logic [3:0] last_wr_addr = 4'h0;
  logic [7:0] last_wr_data = 8'h00;
  logic       s;
  logic [7:0] b;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5ns clk = ~clk;

  i2c_target_regs dut (
    .clk      (clk),
    .rst      (rst),
    .SCL      (scl),
    .SDA      (sda),
    .busy     (busy),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic drive_low, output logic sampled);
    #Q tb_sda_low = drive_low;
    #Q scl = 1'b1;
    #Q sampled = sda;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0;
    scl = 1'b1;
    #Q tb_sda_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    #Q tb_sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q tb_sda_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q tb_sda_low = 1'b1;
    #Q scl = 1'b1;
    #Q tb_sda_low = 1'b0;
    #Q;
  endtask

  // Returns the SDA level seen during the 9th (ACK) clock.
  task automatic send_byte(input logic [7:0] d, output logic ack_lvl);
    logic x;
    for (int i = 7; i >= 0; i--) clk_bit(~d[i], x);
    clk_bit(1'b0, ack_lvl);
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] d);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, x);
      d[i] = x;
    end
    clk_bit(give_ack, x);
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_sda_released", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    check("rst_wr_data", wr_data, 8'h00);
    read_reg(4'h0, b); check("rst_reg0", b, 8'h00);
    read_reg(4'hB, b); check("rst_id_reg", b, 8'hCB);
    rst = 1'b0;
    #(4 * Q);

    // Write 0x01 to register 0xA
    i2c_start();
    send_byte(8'h96, s); check("w1_addr_ack", s, 1'b0);
    check("w1_busy_high", busy, 1'b1);
    send_byte(8'h0A, s); check("w1_ptr_ack", s, 1'b0);
    n0 = strobe_cnt;
    send_byte(8'h01, s); check("w1_data_ack", s, 1'b0);
    i2c_stop();
    check("w1_strobe_count", strobe_cnt - n0, 1);
    check("w1_wr_addr", last_wr_addr, 4'hA);
    check("w1_wr_data", last_wr_data, 8'h01);
    read_reg(4'hA, b); check("w1_reg_a", b, 8'h01);
    check("w1_busy_low", busy, 1'b0);

    // Pointer 0x0B, repeated START, read ID then NACK
    i2c_start();
    send_byte(8'h96, s); check("r1_waddr_ack", s, 1'b0);
    send_byte(8'h0B, s); check("r1_ptr_ack", s, 1'b0);
    i2c_rstart();
    send_byte(8'h97, s); check("r1_raddr_ack", s, 1'b0);
    recv_byte(1'b0, b); check("r1_id_byte", b, 8'hCB);
    check("r1_busy_before_stop", busy, 1'b1);
    i2c_stop();
    check("r1_busy_after_stop", busy, 1'b0);

    // Write to ID register: ACKed and strobed, contents unchanged
    n0 = strobe_cnt;
    i2c_start();
    send_byte(8'h96, s);
    send_byte(8'h0B, s);
    send_byte(8'h77, s); check("id_wr_ack", s, 1'b0);
    i2c_stop();
    check("id_wr_strobe", strobe_cnt - n0, 1);
    check("id_wr_addr", last_wr_addr, 4'hB);
    read_reg(4'hB, b); check("id_unchanged", b, 8'hCB);

    // Three data bytes from pointer 4
    n0 = strobe_cnt;
    i2c_start();
    send_byte(8'h96, s);
    send_byte(8'h04, s);
    send_byte(8'h05, s);
    send_byte(8'h02, s);
    send_byte(8'h04, s); check("multi_last_ack", s, 1'b0);
    i2c_stop();
    check("multi_strobes", strobe_cnt - n0, 3);
`ifdef I2C_TARGET_AUTOINC_EN
    read_reg(4'h4, b); check("multi_reg4", b, 8'h05);
    read_reg(4'h5, b); check("multi_reg5", b, 8'h02);
    read_reg(4'h6, b); check("multi_reg6", b, 8'h04);
`else
    read_reg(4'h4, b); check("multi_reg4", b, 8'h04);
    read_reg(4'h5, b); check("multi_reg5", b, 8'h00);
    read_reg(4'h6, b); check("multi_reg6", b, 8'h00);
`endif

    // Two-byte read from pointer 4 with initiator ACK then NACK
    i2c_start();
    send_byte(8'h96, s);
    send_byte(8'h04, s);
    i2c_rstart();
    send_byte(8'h97, s);
    recv_byte(1'b1, b);
`ifdef I2C_TARGET_AUTOINC_EN
    check("rd2_byte0", b, 8'h05);
    recv_byte(1'b0, b); check("rd2_byte1", b, 8'h02);
`else
    check("rd2_byte0", b, 8'h04);
    recv_byte(1'b0, b); check("rd2_byte1", b, 8'h04);
`endif
    i2c_stop();

    // Foreign address: no ACK, no busy, no strobe
    n0 = strobe_cnt;
    i2c_start();
    send_byte(8'h00, s); check("nomatch_no_ack", s, 1'b1);
    check("nomatch_busy", busy, 1'b0);
    send_byte(8'h55, s); check("nomatch_data_no_ack", s, 1'b1);
    i2c_stop();
    check("nomatch_no_strobe", strobe_cnt - n0, 0);

    // Pointer wrap from 0xF
    i2c_start();
    send_byte(8'h96, s);
    send_byte(8'h0F, s);
    send_byte(8'hAA, s);
    send_byte(8'h55, s); check("wrap_ack", s, 1'b0);
    i2c_stop();
`ifdef I2C_TARGET_AUTOINC_EN
    read_reg(4'hF, b); check("wrap_reg_f", b, 8'hAA);
    read_reg(4'h0, b); check("wrap_reg_0", b, 8'h55);
`else
    read_reg(4'hF, b); check("wrap_reg_f", b, 8'h55);
    read_reg(4'h0, b); check("wrap_reg_0", b, 8'h00);
`endif

    // Reset after the 4th data bit, then the rest of the byte must be ignored
    n0 = strobe_cnt;
    i2c_start();
    send_byte(8'h96, s);
    send_byte(8'h03, s);
    clk_bit(1'b0, s);  // 0x99 = 1001_1001
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_sda", sda, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    read_reg(4'hA, b); check("rstmid_reg_a", b, 8'h00);
    read_reg(4'hB, b); check("rstmid_reg_b", b, 8'hCB);
    rst = 1'b0;
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b0, s); check("rstmid_no_ack", s, 1'b1);
    i2c_stop();
    check("rstmid_no_strobe", strobe_cnt - n0, 0);
    read_reg(4'h3, b); check("rstmid_reg3", b, 8'h00);

    // Next transaction completes normally
    i2c_start();
    send_byte(8'h96, s); check("post_addr_ack", s, 1'b0);
    send_byte(8'h02, s); check("post_ptr_ack", s, 1'b0);
    send_byte(8'h3C, s); check("post_data_ack", s, 1'b0);
    i2c_stop();
    check("post_strobe", strobe_cnt - n0, 1);
    read_reg(4'h2, b); check("post_reg2", b, 8'h3C);
    check("post_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'b1001011, the 7-bit bus address it answers to.
REQ-002 The block SHALL have parameter ID_VALUE, default 8'hCB, the read-only contents of register 0x0B.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port SCL, input, 1, the bus clock driven by the initiator; the block never drives it.
REQ-006 The block SHALL have port SDA, inout, 1, the open-drain bus data line; the block drives only 1'b0 or 'z'.
REQ-007 The block SHALL have port busy, output, 1, high from an address-matched START until STOP.
REQ-008 The block SHALL have port wr_strobe, output, 1, a one-cycle pulse per accepted data byte write.
REQ-009 The block SHALL have port wr_addr, output, 4, the register index of the current wr_strobe.
REQ-010 The block SHALL have port wr_data, output, 8, the data byte of the current wr_strobe.
REQ-011 The block SHALL have port rd_addr, input, 4, the local read index into the register file.
REQ-012 The block SHALL have port rd_data, output, 8, the combinational contents of register rd_addr.

Function
REQ-013 SCL and SDA SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals, 3 clk latency; clk SHALL be at least 20x the SCL rate.
REQ-014 START/repeated START SHALL be SDA falling while SCL high; STOP SHALL be SDA rising while SCL high; either SHALL be honoured in every state.
REQ-015 Bits SHALL be sampled on the SCL rising edge, MSB first; SDA SHALL only change in the clk cycle after a detected SCL falling edge.
REQ-016 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 START SHALL go to ADDR with the bit count cleared; STOP SHALL go to IDLE, release SDA and clear busy.
REQ-018 In ADDR_ACK, a byte[7:1] == DEV_ADDR SHALL pull SDA low for one SCL period; a mismatch SHALL go to IGNORE with SDA released until the next START/STOP.
REQ-019 A matched write (R/W=0) SHALL go to PTR; the byte SHALL load the 4-bit pointer from bits [3:0]; bits [7:4] SHALL be ignored; PTR_ACK SHALL ACK.
REQ-020 Each byte after the pointer SHALL go to WDATA_ACK, be ACKed, and pulse wr_strobe one cycle after the 8th SCL rise with wr_addr = pointer.
REQ-021 A write to pointer 0x0B SHALL be ACKed and pulse wr_strobe, but SHALL NOT change the register.
REQ-022 A matched read (R/W=1) SHALL shift out register[pointer] from the SCL fall ending ADDR_ACK, holding each bit for one SCL period.
REQ-023 In RDATA_ACK, initiator ACK (SDA low) SHALL load the next byte; NACK SHALL release SDA and go to IGNORE until STOP.
REQ-024 The pointer SHALL wrap 0xF -> 0x0.
REQ-025 Register file: 16 x 8, all zero after reset except 0x0B = ID_VALUE; rd_data reflects writes the cycle after wr_strobe.

Reset
REQ-026 While rst is high: FSM=IDLE, SDA released ('z'), busy=0, wr_strobe=0, wr_addr=0, wr_data=0, pointer=0, registers at reset values.
REQ-027 rst asserted mid-transaction SHALL abandon it immediately; after release the block SHALL ignore the bus until the next START.

Configuration
REQ-028 When I2C_TARGET_AUTOINC_EN is defined, the pointer SHALL increment after each data byte in both write and read.
REQ-029 When I2C_TARGET_AUTOINC_EN is undefined, the pointer SHALL stay fixed within a transaction, so repeated bytes hit the same register.

Verification
REQ-030 Write addr 0x4B, ptr 0x0A, data 0x01, STOP -> three ACKs, wr_strobe once with wr_addr=0xA, wr_data=0x01, rd_data(0xA)=0x01.
REQ-031 Write ptr 0x0B, repeated START, read 0x4B|R, NACK -> byte 0xCB returned, busy falls at STOP.
REQ-032 Write ptr 0x04 data 0x05,0x02,0x04 (AUTOINC_EN) -> regs 4/5/6 = 05/02/04; without macro -> reg 4 = 0x04 only.
REQ-033 Address 0x00 write -> no ACK (SDA stays 'z' on 9th clock), busy stays 0, no wr_strobe.
REQ-034 Write ptr 0x0F, two data bytes 0xAA,0x55 (AUTOINC_EN) -> reg F = 0xAA, reg 0 = 0x55.
REQ-035 rst pulsed after the 4th data bit of a write -> SDA released, registers at reset, next valid transaction completes normally.
